// File: rtl/fab_clk_pkg.sv
// Shared state encoding and default timing constants for the fabric clock lock monitor.
package fab_clk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        MEASURE,
        LOCKED
    } fab_state_t;

    localparam int EXP_CYCLES = 1000;
    localparam int TOL        = 8;
    localparam int LOCK_COUNT = 4;

endpackage

// File: rtl/fab_sync_edge.sv
// Two-flop synchronizer with a registered rising-edge pulse for asynchronous strobes.
// A level first captured at cycle n produces a one-cycle pulse at cycle n+2.
module fab_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic rise_pulse
);

    logic sync1;
    logic sync2;
    logic hist;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            hist       <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            sync1      <= async_in;
            sync2      <= sync1;
            hist       <= sync2;
            rise_pulse <= sync2 & ~hist;
        end
    end

endmodule

// File: rtl/fab_clk_lock_monitor.sv
// FAB_CLK-domain lock detector: measures MON_CLK periods and qualifies lock after consecutive good periods.
// Optional macro FAB_LOCK_HYST_EN: while locked, two consecutive bad periods are needed to drop lock.
module fab_clk_lock_monitor
    import fab_clk_pkg::*;
#(
    parameter int EXP_CYCLES = fab_clk_pkg::EXP_CYCLES,
    parameter int TOL        = fab_clk_pkg::TOL,
    parameter int LOCK_COUNT = fab_clk_pkg::LOCK_COUNT,
    parameter int CNT_W      = 16
) (
    input  logic             FAB_CLK,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic             MON_CLK,
    output logic             FAB_LOCK,
    output logic [CNT_W-1:0] PERIOD,
    output logic             PERIOD_VALID,
    output logic             TOO_FAST,
    output logic             TOO_SLOW,
    output logic             STUCK
);

    localparam logic [CNT_W-1:0] LO_LIM    = CNT_W'(EXP_CYCLES - TOL);
    localparam logic [CNT_W-1:0] HI_LIM    = CNT_W'(EXP_CYCLES + TOL);
    localparam logic [CNT_W-1:0] STUCK_LIM = CNT_W'(2 * EXP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [3:0]       LOCK_N    = 4'(LOCK_COUNT);

    fab_state_t       state;
    fab_state_t       state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [3:0]       good_cnt;
    logic [3:0]       good_n;
    logic [CNT_W-1:0] period_n;
    logic             valid_n;
    logic             fast_n;
    logic             slow_n;
    logic             stuck_n;
    logic             rise_pulse;
    logic [CNT_W-1:0] meas;
    logic             is_good;

`ifdef FAB_LOCK_HYST_EN
    logic strike;
    logic strike_n;
`endif

    fab_sync_edge u_sync_edge (
        .clock      (FAB_CLK),
        .reset      (RESET),
        .async_in   (MON_CLK),
        .rise_pulse (rise_pulse)
    );

    assign meas     = cnt + CNT_W'(1);
    assign is_good  = (meas >= LO_LIM) && (meas <= HI_LIM);
    assign FAB_LOCK = (state == LOCKED);

    always_comb begin
        state_n  = state;
        cnt_n    = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
        good_n   = good_cnt;
        period_n = PERIOD;
        valid_n  = 1'b0;
        fast_n   = TOO_FAST;
        slow_n   = TOO_SLOW;
        stuck_n  = STUCK;
`ifdef FAB_LOCK_HYST_EN
        strike_n = strike;
`endif
        if (rise_pulse) begin
            cnt_n = '0;
        end

        case (state)
            IDLE: begin
                cnt_n   = '0;
                state_n = ACQUIRE;
            end
            ACQUIRE: begin
                if (rise_pulse) begin
                    state_n = MEASURE;
                    good_n  = '0;
                end
            end
            MEASURE, LOCKED: begin
                // An edge landing on the stuck threshold still measures a (too slow) period.
                if (rise_pulse) begin
                    period_n = meas;
                    valid_n  = 1'b1;
                    if (meas < LO_LIM) fast_n = 1'b1;
                    if (meas > HI_LIM) slow_n = 1'b1;
                    if (state == MEASURE) begin
                        if (is_good) begin
                            good_n = good_cnt + 4'd1;
                            if (good_cnt + 4'd1 == LOCK_N) state_n = LOCKED;
                        end else begin
                            good_n = '0;
                        end
                    end else if (!is_good) begin
`ifdef FAB_LOCK_HYST_EN
                        if (strike) begin
                            state_n  = MEASURE;
                            good_n   = '0;
                            strike_n = 1'b0;
                        end else begin
                            strike_n = 1'b1;
                        end
`else
                        state_n = MEASURE;
                        good_n  = '0;
`endif
                    end
`ifdef FAB_LOCK_HYST_EN
                    else begin
                        strike_n = 1'b0;
                    end
`endif
                end else if (cnt == STUCK_LIM) begin
                    stuck_n = 1'b1;
                    state_n = ACQUIRE;
                    good_n  = '0;
`ifdef FAB_LOCK_HYST_EN
                    strike_n = 1'b0;
`endif
                end
            end
            default: state_n = IDLE;
        endcase

        // Disabling the monitor outranks everything, including a coincident edge.
        if (!ENABLE) begin
            state_n  = IDLE;
            cnt_n    = '0;
            good_n   = '0;
            period_n = '0;
            valid_n  = 1'b0;
            fast_n   = 1'b0;
            slow_n   = 1'b0;
            stuck_n  = 1'b0;
`ifdef FAB_LOCK_HYST_EN
            strike_n = 1'b0;
`endif
        end
    end

    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            state        <= IDLE;
            cnt          <= '0;
            good_cnt     <= '0;
            PERIOD       <= '0;
            PERIOD_VALID <= 1'b0;
            TOO_FAST     <= 1'b0;
            TOO_SLOW     <= 1'b0;
            STUCK        <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            good_cnt     <= good_n;
            PERIOD       <= period_n;
            PERIOD_VALID <= valid_n;
            TOO_FAST     <= fast_n;
            TOO_SLOW     <= slow_n;
            STUCK        <= stuck_n;
        end
    end

`ifdef FAB_LOCK_HYST_EN
    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            strike <= 1'b0;
        end else begin
            strike <= strike_n;
        end
    end
`endif

endmodule

// File: tb/tb_fab_clk_lock_monitor.sv
// Scoreboard bench for fab_clk_lock_monitor: a period-level model queues the expected strobe contents per MON_CLK edge.
// Expectations follow FAB_LOCK_HYST_EN when the macro is defined for the build.
module tb_fab_clk_lock_monitor;
    import fab_clk_pkg::*;

    localparam int EXP       = 50;
    localparam int TOLR      = 2;
    localparam int LOCKN     = 4;
    localparam int CW        = 16;
    localparam int STUCK_GAP = 2 * EXP + 2;

    logic          FAB_CLK = 1'b0;
    logic          RESET;
    logic          ENABLE;
    logic          MON_CLK;
    logic          FAB_LOCK;
    logic [CW-1:0] PERIOD;
    logic          PERIOD_VALID;
    logic          TOO_FAST;
    logic          TOO_SLOW;
    logic          STUCK;

    typedef struct {
        int period;
        bit lock;
        bit fast;
        bit slow;
        bit stuck;
    } exp_t;

    exp_t       expQ[$];
    int         assertCount = 0;
    int         failCount   = 0;
    fab_state_t mState;
    int         mGood;
    bit         mFast;
    bit         mSlow;
    bit         mStuck;
    int         lastGap;
`ifdef FAB_LOCK_HYST_EN
    bit         mStrike;
`endif

    fab_clk_lock_monitor #(
        .EXP_CYCLES (EXP),
        .TOL        (TOLR),
        .LOCK_COUNT (LOCKN),
        .CNT_W      (CW)
    ) dut (
        .FAB_CLK      (FAB_CLK),
        .RESET        (RESET),
        .ENABLE       (ENABLE),
        .MON_CLK      (MON_CLK),
        .FAB_LOCK     (FAB_LOCK),
        .PERIOD       (PERIOD),
        .PERIOD_VALID (PERIOD_VALID),
        .TOO_FAST     (TOO_FAST),
        .TOO_SLOW     (TOO_SLOW),
        .STUCK        (STUCK)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic modelReset();
        mState  = ACQUIRE;
        mGood   = 0;
        mFast   = 1'b0;
        mSlow   = 1'b0;
        mStuck  = 1'b0;
        lastGap = 0;
`ifdef FAB_LOCK_HYST_EN
        mStrike = 1'b0;
`endif
    endtask

    // Advances the period-level model by one MON_CLK rising edge whose gap to the previous edge is lastGap.
    task automatic modelRise();
        bit   good;
        exp_t e;
        if (mState == ACQUIRE) begin
            mState = MEASURE;
            mGood  = 0;
        end else if (mState == MEASURE || mState == LOCKED) begin
            if (lastGap >= STUCK_GAP) begin
                mStuck = 1'b1;
                mState = MEASURE;
                mGood  = 0;
`ifdef FAB_LOCK_HYST_EN
                mStrike = 1'b0;
`endif
            end else begin
                good = (lastGap >= EXP - TOLR) && (lastGap <= EXP + TOLR);
                if (lastGap < EXP - TOLR) mFast = 1'b1;
                if (lastGap > EXP + TOLR) mSlow = 1'b1;
                if (mState == MEASURE) begin
                    if (good) begin
                        mGood++;
                        if (mGood == LOCKN) mState = LOCKED;
                    end else begin
                        mGood = 0;
                    end
                end else if (!good) begin
`ifdef FAB_LOCK_HYST_EN
                    if (mStrike) begin
                        mState  = MEASURE;
                        mGood   = 0;
                        mStrike = 1'b0;
                    end else begin
                        mStrike = 1'b1;
                    end
`else
                    mState = MEASURE;
                    mGood  = 0;
`endif
                end
`ifdef FAB_LOCK_HYST_EN
                else begin
                    mStrike = 1'b0;
                end
`endif
                e.period = lastGap;
                e.lock   = (mState == LOCKED);
                e.fast   = mFast;
                e.slow   = mSlow;
                e.stuck  = mStuck;
                expQ.push_back(e);
            end
        end
    endtask

    // One MON_CLK period of the given length, starting with a rising edge; called and returns at a negedge.
    task automatic applyStimulus(input int period);
        modelRise();
        MON_CLK = 1'b1;
        repeat (period / 2) @(negedge FAB_CLK);
        MON_CLK = 1'b0;
        repeat (period - period / 2) @(negedge FAB_CLK);
        lastGap = period;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_lock"},   32'(FAB_LOCK),     32'd0);
        checkOutput({tag, "_period"}, 32'(PERIOD),       32'd0);
        checkOutput({tag, "_valid"},  32'(PERIOD_VALID), 32'd0);
        checkOutput({tag, "_fast"},   32'(TOO_FAST),     32'd0);
        checkOutput({tag, "_slow"},   32'(TOO_SLOW),     32'd0);
        checkOutput({tag, "_stuck"},  32'(STUCK),        32'd0);
    endtask

    always @(posedge FAB_CLK) begin
        #1;
        if (PERIOD_VALID === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("spurious_valid", 32'(PERIOD_VALID), 32'd0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("period", 32'(PERIOD),   32'(e.period));
                checkOutput("lock",   32'(FAB_LOCK), 32'(e.lock));
                checkOutput("fast",   32'(TOO_FAST), 32'(e.fast));
                checkOutput("slow",   32'(TOO_SLOW), 32'(e.slow));
                checkOutput("stuck",  32'(STUCK),    32'(e.stuck));
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int tolSeq[11] = '{48, 52, 47, 50, 53, 50, 50, 50, 50, 48, 52};
        bit expStuck;

        RESET   = 1'b1;
        ENABLE  = 1'b0;
        MON_CLK = 1'b0;
        repeat (3) @(negedge FAB_CLK);
        checkAllZero("reset");
        RESET  = 1'b0;
        ENABLE = 1'b1;
        modelReset();
        @(negedge FAB_CLK);

        $display("[TB] lock acquisition");
        repeat (6) applyStimulus(EXP);

        $display("[TB] tolerance boundaries");
        foreach (tolSeq[i]) applyStimulus(tolSeq[i]);

        $display("[TB] lock loss on slow periods");
        repeat (5) applyStimulus(EXP);
        applyStimulus(60);
        applyStimulus(60);
        repeat (6) applyStimulus(EXP);

        $display("[TB] stuck reference");
        repeat (45) @(negedge FAB_CLK);
        checkOutput("stuck_before_timeout", 32'(STUCK),    32'(mStuck));
        checkOutput("lock_before_timeout",  32'(FAB_LOCK), 32'(mState == LOCKED));
        repeat (15) @(negedge FAB_CLK);
        expStuck = (mState == MEASURE || mState == LOCKED) ? 1'b1 : mStuck;
        checkOutput("stuck_after_timeout", 32'(STUCK),    32'(expStuck));
        checkOutput("lock_after_timeout",  32'(FAB_LOCK), 32'd0);
        repeat (40) @(negedge FAB_CLK);
        lastGap += 100;
        repeat (6) applyStimulus(EXP);

        $display("[TB] enable low while locked");
        checkOutput("lock_before_disable", 32'(FAB_LOCK), 32'(mState == LOCKED));
        ENABLE = 1'b0;
        @(negedge FAB_CLK);
        checkAllZero("disable");
        ENABLE = 1'b1;
        modelReset();
        @(negedge FAB_CLK);
        repeat (3) applyStimulus(EXP);

        $display("[TB] reset during measurement");
        RESET = 1'b1;
        @(negedge FAB_CLK);
        checkAllZero("midreset");
        RESET = 1'b0;
        modelReset();
        @(negedge FAB_CLK);
        repeat (6) applyStimulus(EXP);
        checkOutput("relock_after_reset", 32'(FAB_LOCK), 32'(mState == LOCKED));

        repeat (10) @(negedge FAB_CLK);
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
